// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the pipelined gate unit: opcode width and the
// eight gate-select encodings.
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NOT  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XOR  = 3'd5;
  localparam op_t OP_XNOR = 3'd6;
  localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Stream interface of the gate unit: input beat {op,a,b} with valid/ready,
// result beat {y,zero,parity} with valid/ready, plus the transfer counter.
interface logic_gate_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  import logic_gate_pkg::*;

  logic               in_valid;
  logic               in_ready;
  op_t                op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic               zero;
  logic               parity;
  logic [COUNT_W-1:0] op_count;

  // Producer/consumer side of the stream
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, parity, op_count
  );

  // Gate unit side of the stream
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, parity, op_count
  );

endinterface

// File: rtl/logic_gate_pipe_alu.sv
// Purely combinational bitwise gate: y = f(op, a, b). b is ignored for
// NOT and PASS.
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the gate function for the current opcode
  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage pipelined gate unit. Stage 1 captures {op,a,b}; stage 2 captures
// the gate result together with its zero/parity flags. A saturating counter
// tracks output transfers; clr flushes both stages and clears the counter.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clr,
  logic_gate_pipe_if.slave  bus
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1'b1);

  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic calc_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  logic               s1_valid_r;
  op_t                s1_op_r;
  logic [WIDTH-1:0]   s1_a_r;
  logic [WIDTH-1:0]   s1_b_r;
  logic               s2_valid_r;
  logic [WIDTH-1:0]   y_r;
  logic               zero_r;
  logic               parity_r;
  logic [COUNT_W-1:0] count_r;

  logic               adv1_s;
  logic               adv2_s;
  logic               in_ready_s;
  logic               in_xfer_s;
  logic               out_xfer_s;
  logic [WIDTH-1:0]   alu_y_s;

  // Stage 2 may load when empty or draining; stage 1 may load when empty or
  // when stage 2 takes its beat. Input is blocked during clr and reset.
  assign adv2_s     = !s2_valid_r | bus.out_ready;
  assign adv1_s     = !s1_valid_r | adv2_s;
  assign in_ready_s = adv1_s & !clr & rst_n;
  assign in_xfer_s  = bus.in_valid & in_ready_s;
  assign out_xfer_s = s2_valid_r & bus.out_ready;

  logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .op (s1_op_r),
    .a  (s1_a_r),
    .b  (s1_b_r),
    .y  (alu_y_s)
  );

  // Stage 1: capture the operand beat on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= OP_AND;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
    end else if (clr) begin
      s1_valid_r <= 1'b0;
    end else if (adv1_s) begin
      s1_valid_r <= in_xfer_s;
      if (in_xfer_s) begin
        s1_op_r <= bus.op;
        s1_a_r  <= bus.a;
        s1_b_r  <= bus.b;
      end
    end
  end

  // Stage 2: register the gate result and its flags; data only moves on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      y_r        <= {WIDTH{1'b0}};
      zero_r     <= 1'b0;
      parity_r   <= 1'b0;
    end else if (clr) begin
      s2_valid_r <= 1'b0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        y_r      <= alu_y_s;
        zero_r   <= calc_zero(alu_y_s);
        parity_r <= calc_parity(alu_y_s);
      end
    end
  end

  // Saturating output-transfer counter; clr wins over a same-cycle transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (out_xfer_s && (count_r != COUNT_MAX)) begin
      count_r <= count_r + COUNT_ONE;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.y         = y_r;
  assign bus.zero      = zero_r;
  assign bus.parity    = parity_r;
  assign bus.op_count  = count_r;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe (WIDTH=8, COUNT_W=4). Stimulus pushes
// hand-computed results into a queue; a monitor pops and compares on every
// output transfer.
module tb_logic_gate_pipe;

  logic clk;
  logic rst_n;
  logic clr;
  int   cyc;
  int   n_cmp;
  int   n_err;

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       p;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  logic_gate_pipe_if #(.WIDTH(8), .COUNT_W(4)) bus ();

  logic_gate_pipe #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output transfer (not overridden by clr) is checked against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready && !clr) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(bus.y), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("y", 32'(bus.y), 32'(e.y));
          check("zero", 32'(bus.zero), 32'(e.z));
          check("parity", 32'(bus.parity), 32'(e.p));
          if (e.cyc >= 0) check("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic send(input logic [2:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                      input logic [7:0] ey, input bit chk_lat);
    exp_t e;
    bit   done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op_i;
    bus.a  = a_i;
    bus.b  = b_i;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.y   = ey;
        e.z   = (ey == 8'h00);
        e.p   = ^ey;
        e.cyc = chk_lat ? cyc + 2 : -1;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_parity", 32'(bus.parity), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // 1. Opcode sweep, back to back, latency checked
    send(3'd0, 8'hA5, 8'h0F, 8'h05, 1'b1);
    send(3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b1);
    send(3'd2, 8'hA5, 8'h0F, 8'h5A, 1'b1);
    send(3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b1);
    send(3'd4, 8'hA5, 8'h0F, 8'h50, 1'b1);
    send(3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b1);
    send(3'd6, 8'hA5, 8'h0F, 8'h55, 1'b1);
    send(3'd7, 8'hA5, 8'h0F, 8'hA5, 1'b1);
    drain();
    check("count_after_sweep", 32'(bus.op_count), 32'd8);

    // 2. Backpressure: two accepts fill the pipe, then y must hold
    bus.out_ready = 1'b0;
    send(3'd0, 8'hFF, 8'h0F, 8'h0F, 1'b0);
    send(3'd1, 8'h30, 8'h03, 8'h33, 1'b0);
    bus.in_valid = 1'b1;
    bus.op = 3'd5;
    bus.a  = 8'hFF;
    bus.b  = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_y_hold", 32'(bus.y), 32'h0F);
      @(posedge clk);
      #1;
    end
    check("bp_count_hold", 32'(bus.op_count), 32'd8);
    bus.out_ready = 1'b1;
    send(3'd5, 8'hFF, 8'h01, 8'hFE, 1'b0);
    send(3'd4, 8'h0F, 8'hF0, 8'h00, 1'b0);
    drain();
    check("count_after_bp", 32'(bus.op_count), 32'd12);

    // 3. Flags
    send(3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1);
    send(3'd7, 8'h07, 8'h00, 8'h07, 1'b1);
    drain();
    check("count_after_flags", 32'(bus.op_count), 32'd14);

    // 4. Saturation from a cleared counter
    clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_count", 32'(bus.op_count), 32'd0);
    for (int i = 1; i <= 14; i++) send(3'd7, 8'(i), 8'h00, 8'(i), 1'b0);
    drain();
    check("sat_count_14", 32'(bus.op_count), 32'd14);
    send(3'd7, 8'h0F, 8'h00, 8'h0F, 1'b0);
    drain();
    check("sat_count_15", 32'(bus.op_count), 32'd15);
    for (int i = 16; i <= 20; i++) send(3'd7, 8'(i), 8'h00, 8'(i), 1'b0);
    drain();
    check("sat_count_hold", 32'(bus.op_count), 32'd15);

    // 5. clr with both stages full and an output transfer pending
    bus.out_ready = 1'b0;
    send(3'd5, 8'h3C, 8'hFF, 8'hC3, 1'b0);
    send(3'd4, 8'h00, 8'h01, 8'hFE, 1'b0);
    bus.out_ready = 1'b1;
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 3'd7;
    bus.a  = 8'h99;
    @(negedge clk);
    check("clr5_in_ready", 32'(bus.in_ready), 32'd0);
    check("clr5_out_valid_pre", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("clr5_out_valid", 32'(bus.out_valid), 32'd0);
    check("clr5_count", 32'(bus.op_count), 32'd0);
    repeat (3) @(negedge clk);
    check("clr5_no_leak", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // 6. Asynchronous reset mid-stream
    send(3'd1, 8'h12, 8'h34, 8'h36, 1'b0);
    send(3'd3, 8'hFF, 8'hFF, 8'h00, 1'b0);
    send(3'd6, 8'h0F, 8'h0F, 8'hFF, 1'b0);
    drain();
    check("pre_rst_count", 32'(bus.op_count), 32'd3);
    send(3'd0, 8'hFF, 8'h3C, 8'h3C, 1'b0);
    send(3'd1, 8'h40, 8'h01, 8'h41, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_y", 32'(bus.y), 32'd0);
    check("arst_count", 32'(bus.op_count), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'd2, 8'h0F, 8'h00, 8'hF0, 1'b1);
    drain();
    check("post_rst_count", 32'(bus.op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
